// File: rtl/izh_spike_decoder.sv
// Spike detector for the neuron's 2.6 voltage stream: threshold/hysteresis/refractory FSM,
// ISI measurement and a record FIFO. Optional rate window when IZH_SPIKE_DEC_RATE_EN is defined.
module izh_spike_decoder #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REFRACT_SAMPLES = 2,
    parameter int unsigned BURST_ISI       = 8
`ifdef IZH_SPIKE_DEC_RATE_EN
    ,
    parameter int unsigned RATE_WINDOW     = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  v_in,
    input  logic        v_valid,
    input  logic [7:0]  thr,
    input  logic [3:0]  hyst,
    output logic        spike,
    output logic [17:0] isi_data,
    output logic        isi_valid,
    input  logic        isi_ready,
    output logic        overflow,
    output logic [7:0]  rate,
    output logic        rate_valid
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REF_W = (REFRACT_SAMPLES > 1) ? $clog2(REFRACT_SAMPLES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRACT_SAMPLES - 1);

    typedef struct packed {
        logic        first;
        logic        burst;
        logic [15:0] isi;
    } rec_t;

    // COOL is the post-spike disarmed state; it leads to REFRACT rather than ARMED.
    typedef enum logic [1:0] {
        ST_DISARM  = 2'd0,
        ST_ARMED   = 2'd1,
        ST_COOL    = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic signed [8:0]  v_s, thr_s, arm_s;
    logic               below_c, above_c, fire_c;

    logic [15:0]        isi_cnt_q, isi_inc_c;
    logic               first_q;
    logic               spike_q;
    logic               overflow_q;
    rec_t               rec_c;
    rec_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q;
    logic               pop_c, full_c, push_ok_c, drop_c;

    assign v_s     = {v_in[7], v_in};
    assign thr_s   = {thr[7], thr};
    assign arm_s   = thr_s - $signed({5'b0, hyst});
    assign below_c = v_s < arm_s;
    assign above_c = v_s >= thr_s;

    // Detector state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DISARM;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
        end
    end

    // Detector next state; only valid samples advance it
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        fire_c  = 1'b0;
        if (v_valid) begin
            unique case (state_q)
                ST_DISARM: if (below_c) state_d = ST_ARMED;
                ST_ARMED: begin
                    if (above_c) begin
                        fire_c  = 1'b1;
                        state_d = ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (below_c) begin
                        if (REFRACT_SAMPLES == 0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_REFRACT;
                            ref_d   = '0;
                        end
                    end
                end
                ST_REFRACT: begin
                    if (ref_q == REF_LAST) state_d = ST_ARMED;
                    else                   ref_d   = ref_q + 1'b1;
                end
                default: state_d = ST_DISARM;
            endcase
        end
    end

    // Record assembly and FIFO control
    always_comb begin
        isi_inc_c = (isi_cnt_q == 16'hFFFF) ? 16'hFFFF : isi_cnt_q + 16'd1;
        rec_c.isi   = isi_inc_c;
        rec_c.first = first_q;
        rec_c.burst = !first_q && (32'(isi_inc_c) <= BURST_ISI);
        pop_c     = valid_q && isi_ready;
        full_c    = count_q == CNT_W'(FIFO_DEPTH);
        push_ok_c = fire_c && (!full_c || pop_c);
        drop_c    = fire_c && full_c && !pop_c;
        count_d   = count_q;
        unique case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt_q  <= '0;
            first_q    <= 1'b1;
            spike_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            spike_q <= fire_c;
            if (v_valid) isi_cnt_q <= fire_c ? 16'd0 : isi_inc_c;
            if (fire_c) first_q <= 1'b0;
            if (drop_c) overflow_q <= 1'b1;
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= rec_c;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            valid_q <= count_d != '0;
        end
    end

    assign spike     = spike_q;
    assign overflow  = overflow_q;
    assign isi_valid = valid_q;
    assign isi_data  = mem_q[rd_ptr_q];

`ifdef IZH_SPIKE_DEC_RATE_EN
    localparam int unsigned WIN_W = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(RATE_WINDOW - 1);

    logic [WIN_W-1:0] win_q;
    logic [7:0]       spk_cnt_q, spk_inc_c, rate_q;
    logic             rate_valid_q;

    assign spk_inc_c = (fire_c && spk_cnt_q != 8'hFF) ? spk_cnt_q + 8'd1 : spk_cnt_q;

    // Window counter; the closing sample's spike is included in the published count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q        <= '0;
            spk_cnt_q    <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            rate_valid_q <= 1'b0;
            if (v_valid) begin
                if (win_q == WIN_LAST) begin
                    rate_q       <= spk_inc_c;
                    rate_valid_q <= 1'b1;
                    spk_cnt_q    <= '0;
                    win_q        <= '0;
                end else begin
                    win_q     <= win_q + 1'b1;
                    spk_cnt_q <= spk_inc_c;
                end
            end
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
`else
    assign rate       = 8'd0;
    assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_izh_spike_decoder.sv
// Directed bench for izh_spike_decoder: arming, refractory, ISI records, FIFO, saturation, rate.
module tb_izh_spike_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  v_in;
    logic        v_valid;
    logic [7:0]  thr;
    logic [3:0]  hyst;
    logic        spike;
    logic [17:0] isi_data;
    logic        isi_valid;
    logic        isi_ready;
    logic        overflow;
    logic [7:0]  rate;
    logic        rate_valid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    izh_spike_decoder dut (
        .clk(clk), .rst_n(rst_n), .v_in(v_in), .v_valid(v_valid), .thr(thr), .hyst(hyst),
        .spike(spike), .isi_data(isi_data), .isi_valid(isi_valid), .isi_ready(isi_ready),
        .overflow(overflow), .rate(rate), .rate_valid(rate_valid)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; v_valid = 1'b0; isi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One valid sample, then outputs are observed 1 time unit after the edge
    task automatic step(input logic [7:0] v);
        v_in = v; v_valid = 1'b1;
        @(posedge clk); #1;
        v_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic spike_after(input int n_low, input logic pop_on_cross, input string name);
        for (int i = 0; i < n_low; i++) step(8'h10);
        isi_ready = pop_on_cross;
        step(8'h30);
        isi_ready = 1'b0;
        n_checks++;
        if (spike !== 1'b1) $display("FAIL %s spike: got %b want 1", name, spike);
        else n_pass++;
    endtask

    task automatic drain_one(input logic [17:0] exp, input string name);
        n_checks++;
        if ({isi_valid, isi_data} !== {1'b1, exp})
            $display("FAIL %s: got valid=%b data=%h want valid=1 data=%h", name, isi_valid, isi_data, exp);
        else n_pass++;
        isi_ready = 1'b1;
        idle();
        isi_ready = 1'b0;
    endtask

    task automatic test_reset();
        v_in = 8'h40; thr = 8'h20; hyst = 4'd4;
        do_reset();
        n_checks++;
        if ({spike, isi_valid, overflow, isi_data, rate, rate_valid} !== 29'd0)
            $display("FAIL reset_outputs: got spk=%b v=%b ovf=%b data=%h rate=%h rv=%b want all 0",
                     spike, isi_valid, overflow, isi_data, rate, rate_valid);
        else n_pass++;
        step(8'h40); step(8'h40); step(8'h40);
        step(8'h1C);
        step(8'h20);
        n_checks++;
        if (spike !== 1'b0) $display("FAIL reset_no_fire_unarmed: got %b want 0", spike);
        else n_pass++;
        step(8'h1B);
        step(8'h20);
        n_checks++;
        if (spike !== 1'b1) $display("FAIL arm_then_fire: got %b want 1", spike);
        else n_pass++;
        n_checks++;
        if ({isi_valid, isi_data} !== {1'b1, 1'b1, 1'b0, 16'd7})
            $display("FAIL first_record_latency: got v=%b data=%h want v=1 data=%h",
                     isi_valid, isi_data, {1'b1, 1'b0, 16'd7});
        else n_pass++;
        idle();
        n_checks++;
        if (spike !== 1'b0) $display("FAIL spike_one_cycle: got %b want 0", spike);
        else n_pass++;
    endtask

    task automatic test_first_and_refract();
        do_reset();
        step(8'h10); step(8'h10); step(8'h10); step(8'h30);
        n_checks++;
        if ({spike, isi_valid, isi_data} !== {1'b1, 1'b1, 1'b1, 1'b0, 16'd4})
            $display("FAIL first_isi: got spk=%b v=%b data=%h want 1 1 %h",
                     spike, isi_valid, isi_data, {1'b1, 1'b0, 16'd4});
        else n_pass++;
        step(8'h10);
        step(8'h30);
        n_checks++;
        if (spike !== 1'b0) $display("FAIL refract_ignore: got %b want 0", spike);
        else n_pass++;
        v_in = 8'h7F; idle();
        step(8'h30);
        n_checks++;
        if (spike !== 1'b0) $display("FAIL refract_ignore2: got %b want 0", spike);
        else n_pass++;
        drain_one({1'b1, 1'b0, 16'd4}, "pop_first");
        n_checks++;
        if (isi_valid !== 1'b0) $display("FAIL pop_empty: got %b want 0", isi_valid);
        else n_pass++;
        step(8'h10); step(8'h10); step(8'h30);
        n_checks++;
        if ({spike, isi_valid, isi_data} !== {1'b1, 1'b1, 1'b0, 1'b1, 16'd6})
            $display("FAIL burst_isi: got spk=%b v=%b data=%h want 1 1 %h",
                     spike, isi_valid, isi_data, {1'b0, 1'b1, 16'd6});
        else n_pass++;
        drain_one({1'b0, 1'b1, 16'd6}, "pop_second");
    endtask

    task automatic test_overflow();
        do_reset();
        spike_after(1, 1'b0, "ovf_s1");
        spike_after(3, 1'b0, "ovf_s2");
        spike_after(5, 1'b0, "ovf_s3");
        spike_after(8, 1'b0, "ovf_s4");
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL overflow_early: got %b want 0", overflow);
        else n_pass++;
        spike_after(12, 1'b0, "ovf_s5");
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL overflow_set: got %b want 1", overflow);
        else n_pass++;
        drain_one({1'b1, 1'b0, 16'd2}, "ovf_rec0");
        drain_one({1'b0, 1'b1, 16'd4}, "ovf_rec1");
        drain_one({1'b0, 1'b1, 16'd6}, "ovf_rec2");
        drain_one({1'b0, 1'b0, 16'd9}, "ovf_rec3");
        n_checks++;
        if ({isi_valid, overflow} !== 2'b01)
            $display("FAIL ovf_drained: got v=%b ovf=%b want v=0 ovf=1", isi_valid, overflow);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        spike_after(3, 1'b0, "mid_pre");
        step(8'h10);
        rst_n = 1'b0; v_in = 8'h10; v_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; v_valid = 1'b0;
        n_checks++;
        if ({isi_valid, overflow, spike} !== 3'b000)
            $display("FAIL mid_reset: got v=%b ovf=%b spk=%b want 0 0 0", isi_valid, overflow, spike);
        else n_pass++;
        spike_after(1, 1'b0, "mid_post");
        drain_one({1'b1, 1'b0, 16'd2}, "mid_first_again");
    endtask

    task automatic test_back_to_back();
        do_reset();
        spike_after(1, 1'b0, "b2b_s1");
        spike_after(3, 1'b0, "b2b_s2");
        spike_after(3, 1'b0, "b2b_s3");
        spike_after(3, 1'b0, "b2b_s4");
        spike_after(10, 1'b1, "b2b_s5");
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL full_pop_push_no_drop: got ovf=%b want 0", overflow);
        else n_pass++;
        drain_one({1'b0, 1'b1, 16'd4}, "b2b_rec0");
        drain_one({1'b0, 1'b1, 16'd4}, "b2b_rec1");
        drain_one({1'b0, 1'b1, 16'd4}, "b2b_rec2");
        drain_one({1'b0, 1'b0, 16'd11}, "b2b_rec3");
        n_checks++;
        if (isi_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", isi_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        v_in = 8'h10; v_valid = 1'b1;
        repeat (65600) @(posedge clk);
        #1 v_valid = 1'b0;
        step(8'h30);
        n_checks++;
        if ({spike, isi_valid, isi_data} !== {1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF})
            $display("FAIL isi_saturate: got spk=%b v=%b data=%h want 1 1 %h",
                     spike, isi_valid, isi_data, {1'b1, 1'b0, 16'hFFFF});
        else n_pass++;
    endtask

    task automatic test_rate();
        int unsigned bad = 0;
        do_reset();
        isi_ready = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step((i >= 31 && (i % 25) == 6) ? 8'h30 : 8'h10);
`ifdef IZH_SPIKE_DEC_RATE_EN
            if (i < 256 && rate_valid !== 1'b0) bad++;
`else
            if ({rate, rate_valid} !== 9'd0) bad++;
`endif
        end
        isi_ready = 1'b0;
`ifdef IZH_SPIKE_DEC_RATE_EN
        n_checks++;
        if ({rate_valid, rate} !== {1'b1, 8'd10})
            $display("FAIL rate_update: got rv=%b rate=%0d want rv=1 rate=10", rate_valid, rate);
        else n_pass++;
        idle();
        if ({rate_valid, rate} !== {1'b0, 8'd10}) bad++;
`else
        idle();
        if ({rate, rate_valid} !== 9'd0) bad++;
`endif
        n_checks++;
        if (bad !== 0) $display("FAIL rate_quiet: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; v_in = 8'h00; v_valid = 1'b0; thr = 8'h20; hyst = 4'd4; isi_ready = 1'b0;
        test_reset();
        test_first_and_refract();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        test_rate();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
